// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
// State encoding and the default 8b/10b-style comma symbol.
package serial_paralelo_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/sp_comma_detect.sv
// Serial shift register with comma match.
// Bits enter at the LSB, so the first bit received ends up as the MSB.
module sp_comma_detect
    import serial_paralelo_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(K28_5)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_sr,
    output logic             o_is_comma
);

    logic [WIDTH-1:0] r_sr;

    // Shift one serial bit in per clock, MSB first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[WIDTH-2:0], i_data};
        end
    end

    assign o_sr       = r_sr;
    assign o_is_comma = (r_sr == COMMA);

endmodule

// File: rtl/serial_paralelo_sync.sv
// Deserializer with comma hunt, lock tracking and word delivery.
// Word timing comes from a phase counter on the bit clock only.
module serial_paralelo_sync
    import serial_paralelo_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(K28_5),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic             active,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             comma_out,
    output logic             align_err
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    localparam logic [PW-1:0] PH_LAST  = PW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_COUNT - 1);

    logic [WIDTH-1:0] w_sr;
    logic             w_is_comma;
    logic             w_boundary;
    logic [PW-1:0]    w_ph_next;

    state_t           r_state;
    logic [PW-1:0]    r_ph;
    logic [CW-1:0]    r_comma_cnt;
    logic [MW-1:0]    r_miss_cnt;
    logic             r_active;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_comma;
    logic             r_err;

    sp_comma_detect #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_detect (
        .i_clk      (clk_32f),
        .i_rst_n    (reset),
        .i_data     (data_in),
        .o_sr       (w_sr),
        .o_is_comma (w_is_comma)
    );

    assign w_boundary = (r_ph == PH_LAST);
    assign w_ph_next  = w_boundary ? '0 : r_ph + PW'(1);

    // Alignment FSM: hunt any offset, confirm commas, then deliver words.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_ph        <= '0;
            r_comma_cnt <= '0;
            r_miss_cnt  <= '0;
            r_active    <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_comma     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_comma <= 1'b0;
            r_err   <= 1'b0;
            r_ph    <= w_ph_next;
            unique case (r_state)
                ST_HUNT: begin
                    if (w_is_comma) begin
                        r_ph        <= '0;
                        r_comma_cnt <= CW'(1);
                        r_miss_cnt  <= '0;
                        if (LOCK_COUNT == 1) begin
                            r_state  <= ST_LOCKED;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    if (w_boundary) begin
                        if (!w_is_comma) begin
                            r_state     <= ST_HUNT;
                            r_comma_cnt <= '0;
                        end else if (r_comma_cnt == CNT_LAST) begin
                            r_comma_cnt <= r_comma_cnt + CW'(1);
                            r_state     <= ST_LOCKED;
                            r_active    <= 1'b1;
                        end else begin
                            r_comma_cnt <= r_comma_cnt + CW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            r_comma    <= 1'b1;
                            r_miss_cnt <= '0;
                        end else begin
                            r_data  <= w_sr;
                            r_valid <= 1'b1;
                        end
                    end else if (w_is_comma) begin
                        if (r_miss_cnt == MISS_LAST) begin
                            r_state     <= ST_HUNT;
                            r_active    <= 1'b0;
                            r_err       <= 1'b1;
                            r_comma_cnt <= '0;
                            r_miss_cnt  <= '0;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + MW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                end
            endcase
        end
    end

    assign active    = r_active;
    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign comma_out = r_comma;
    assign align_err = r_err;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Bench for serial_paralelo_sync: default 8-bit instance plus a
// 10-bit, single-comma-lock instance, against a word-level model.
module tb_serial_paralelo_sync;

    localparam logic [7:0] K1 = 8'hBC;
    localparam logic [9:0] K2 = 10'h17C;

    typedef struct {
        bit          lock;
        int          run;
        logic [15:0] last;
    } mst_t;

    typedef struct {
        bit          valid;
        bit          comma;
        bit          active;
        logic [15:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst1, din1, act1, val1, cma1, err1;
    logic [7:0] dout1;
    logic       rst2, din2, act2, val2, cma2, err2;
    logic [9:0] dout2;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;

    logic        s_val, s_cma, s_err, s_act;
    logic [15:0] s_data;
    bit          s_quiet;

    always #5 clk = ~clk;

    always @(negedge clk) if (err1 === 1'b1) err_pulses++;

    serial_paralelo_sync #(
        .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_COUNT(3)
    ) u_dut (
        .clk_32f(clk), .reset(rst1), .data_in(din1),
        .active(act1), .valid_out(val1), .data_out(dout1),
        .comma_out(cma1), .align_err(err1)
    );

    serial_paralelo_sync #(
        .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1), .LOSS_COUNT(3)
    ) u_dut10 (
        .clk_32f(clk), .reset(rst2), .data_in(din2),
        .active(act2), .valid_out(val2), .data_out(dout2),
        .comma_out(cma2), .align_err(err2)
    );

    // Word-level reference: commas build lock, then words or idles.
    task automatic model(inout mst_t s, input logic [15:0] w,
                         input logic [15:0] k, input int lc,
                         output exp_t e);
        e.valid = 1'b0;
        e.comma = 1'b0;
        if (!s.lock) begin
            if (w == k) begin
                s.run = s.run + 1;
                if (s.run >= lc) s.lock = 1'b1;
            end else begin
                s.run = 0;
            end
        end else if (w == k) begin
            e.comma = 1'b1;
        end else begin
            e.valid = 1'b1;
            s.last  = w;
        end
        e.active = s.lock;
        e.data   = s.last;
    endtask

    task automatic tick1(input logic b);
        @(negedge clk);
        din1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic tick2(input logic b);
        @(negedge clk);
        din2 = b;
        @(posedge clk);
        #1;
    endtask

    // Snapshot after the first bit shows the previous word's outcome.
    task automatic send8(input logic [7:0] w);
        s_quiet = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick1(w[i]);
            if (i == 7) begin
                s_val  = val1;
                s_cma  = cma1;
                s_err  = err1;
                s_act  = act1;
                s_data = {8'h00, dout1};
            end else if ((val1 | cma1 | err1) !== 1'b0) begin
                s_quiet = 1'b0;
            end
        end
    endtask

    task automatic send10(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            tick2(w[i]);
            if (i == 9) begin
                s_val  = val2;
                s_cma  = cma2;
                s_err  = err2;
                s_act  = act2;
                s_data = {6'h00, dout2};
            end
        end
    endtask

    task automatic do_reset1;
        rst1 = 1'b0;
        din1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b1;
    endtask

    task automatic test_reset;
        rst1 = 1'b0; din1 = 1'b0;
        rst2 = 1'b0; din2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL reset.active got=%b exp=0", act1); end
        checks++; if (val1 !== 1'b0) begin errors++; $display("FAIL reset.valid got=%b exp=0", val1); end
        checks++; if (dout1 !== 8'h00) begin errors++; $display("FAIL reset.data got=%h exp=00", dout1); end
        checks++; if (cma1 !== 1'b0) begin errors++; $display("FAIL reset.comma got=%b exp=0", cma1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset.err got=%b exp=0", err1); end
        checks++; if (dout2 !== 10'h000) begin errors++; $display("FAIL reset.data10 got=%h exp=000", dout2); end
    endtask

    task automatic test_lock;
        logic [7:0] ws[$];
        mst_t m;
        exp_t pe;
        bit   have;
        m = '{lock: 1'b0, run: 0, last: 16'h0};
        do_reset1();
        repeat (3) tick1(1'($urandom));
        repeat (4) ws.push_back(K1);
        ws.push_back(8'h55);
        ws.push_back(8'hA3);
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 2) == 0) ws.push_back(K1);
            else ws.push_back(8'($urandom) & 8'h6D);
        end
        ws.push_back(K1);
        have = 1'b0;
        foreach (ws[j]) begin
            send8(ws[j]);
            if (have) begin
                checks++; if (s_val !== pe.valid) begin errors++; $display("FAIL lock.valid w=%0d got=%b exp=%b", j-1, s_val, pe.valid); end
                checks++; if (s_cma !== pe.comma) begin errors++; $display("FAIL lock.comma w=%0d got=%b exp=%b", j-1, s_cma, pe.comma); end
                checks++; if (s_act !== pe.active) begin errors++; $display("FAIL lock.active w=%0d got=%b exp=%b", j-1, s_act, pe.active); end
                checks++; if (s_data !== pe.data) begin errors++; $display("FAIL lock.data w=%0d got=%h exp=%h", j-1, s_data, pe.data); end
                checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL lock.err w=%0d got=%b exp=0", j-1, s_err); end
                checks++; if (s_quiet !== 1'b1) begin errors++; $display("FAIL lock.quiet w=%0d got=%b exp=1", j, s_quiet); end
            end
            model(m, {8'h00, ws[j]}, {8'h00, K1}, 4, pe);
            have = 1'b1;
        end
    endtask

    task automatic test_broken_sync;
        logic [7:0] ws[$];
        mst_t m;
        exp_t pe;
        bit   have;
        m = '{lock: 1'b0, run: 0, last: 16'h0};
        do_reset1();
        repeat (2) tick1(1'($urandom));
        ws = '{K1, K1, 8'h00, K1, K1, K1, K1};
        ws.push_back(8'($urandom) & 8'h6D);
        ws.push_back(K1);
        have = 1'b0;
        foreach (ws[j]) begin
            send8(ws[j]);
            if (have) begin
                checks++; if (s_act !== pe.active) begin errors++; $display("FAIL broken.active w=%0d got=%b exp=%b", j-1, s_act, pe.active); end
                checks++; if (s_val !== pe.valid) begin errors++; $display("FAIL broken.valid w=%0d got=%b exp=%b", j-1, s_val, pe.valid); end
                checks++; if (s_data !== pe.data) begin errors++; $display("FAIL broken.data w=%0d got=%h exp=%h", j-1, s_data, pe.data); end
            end
            model(m, {8'h00, ws[j]}, {8'h00, K1}, 4, pe);
            have = 1'b1;
        end
    endtask

    task automatic test_loss;
        int p0;
        do_reset1();
        repeat (4) send8(K1);
        send8(8'h55);
        send8(8'h24);
        checks++; if (s_act !== 1'b1) begin errors++; $display("FAIL loss.locked got=%b exp=1", s_act); end
        checks++; if (s_data !== 16'h0055) begin errors++; $display("FAIL loss.data got=%h exp=0055", s_data); end
        p0 = err_pulses;
        repeat (3) tick1(1'b0);
        send8(K1);
        repeat (5) tick1(1'b0);
        send8(K1);
        send8(8'h24);
        checks++; if (s_cma !== 1'b1) begin errors++; $display("FAIL loss.one_shift_comma got=%b exp=1", s_cma); end
        checks++; if (s_act !== 1'b1) begin errors++; $display("FAIL loss.one_shift_active got=%b exp=1", s_act); end
        repeat (3) tick1(1'b0);
        send8(K1);
        repeat (3) tick1(1'b0);
        send8(K1);
        repeat (2) tick1(1'b0);
        send8(K1);
        send8(8'h24);
        checks++; if (s_cma !== 1'b1) begin errors++; $display("FAIL loss.two_shift_comma got=%b exp=1", s_cma); end
        checks++; if (s_act !== 1'b1) begin errors++; $display("FAIL loss.two_shift_active got=%b exp=1", s_act); end
        checks++; if (err_pulses - p0 !== 0) begin errors++; $display("FAIL loss.no_err got=%0d exp=0", err_pulses - p0); end
        for (int n = 0; n < 3; n++) begin
            repeat (3) tick1(1'b0);
            send8(K1);
        end
        tick1(1'b0);
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL loss.err got=%b exp=1", err1); end
        checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL loss.active got=%b exp=0", act1); end
        tick1(1'b0);
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL loss.err_drop got=%b exp=0", err1); end
        checks++; if (err_pulses - p0 !== 1) begin errors++; $display("FAIL loss.err_count got=%0d exp=1", err_pulses - p0); end
    endtask

    task automatic test_async_reset;
        logic [7:0] w;
        do_reset1();
        repeat (3) tick1(1'($urandom));
        repeat (4) send8(K1);
        send8(8'hA3);
        send8(8'h55);
        checks++; if (s_data !== 16'h00A3) begin errors++; $display("FAIL arst.pre_data got=%h exp=00a3", s_data); end
        repeat (5) tick1(1'b0);
        #1;
        rst1 = 1'b0;
        #1;
        checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL arst.active got=%b exp=0", act1); end
        checks++; if (dout1 !== 8'h00) begin errors++; $display("FAIL arst.data got=%h exp=00", dout1); end
        checks++; if (val1 !== 1'b0) begin errors++; $display("FAIL arst.valid got=%b exp=0", val1); end
        checks++; if ((cma1 | err1) !== 1'b0) begin errors++; $display("FAIL arst.strobes got=%b exp=0", cma1 | err1); end
        @(negedge clk);
        rst1 = 1'b1;
        w = 8'($urandom) & 8'h6D;
        repeat (3) send8(K1);
        send8(K1);
        checks++; if (s_act !== 1'b0) begin errors++; $display("FAIL arst.early_active got=%b exp=0", s_act); end
        send8(w);
        send8(K1);
        checks++; if (s_act !== 1'b1) begin errors++; $display("FAIL arst.relock got=%b exp=1", s_act); end
        checks++; if (s_val !== 1'b1) begin errors++; $display("FAIL arst.valid2 got=%b exp=1", s_val); end
        checks++; if (s_data !== {8'h00, w}) begin errors++; $display("FAIL arst.data2 got=%h exp=%h", s_data, w); end
    endtask

    task automatic test_param;
        logic [9:0] ws[$];
        mst_t m;
        exp_t pe;
        bit   have;
        m = '{lock: 1'b0, run: 0, last: 16'h0};
        @(negedge clk);
        rst2 = 1'b1;
        tick2(1'b0);
        tick2(1'b1);
        ws = '{K2, 10'h2A5, K2, 10'h0A5, K2};
        have = 1'b0;
        foreach (ws[j]) begin
            send10(ws[j]);
            if (have) begin
                checks++; if (s_act !== pe.active) begin errors++; $display("FAIL w10.active w=%0d got=%b exp=%b", j-1, s_act, pe.active); end
                checks++; if (s_val !== pe.valid) begin errors++; $display("FAIL w10.valid w=%0d got=%b exp=%b", j-1, s_val, pe.valid); end
                checks++; if (s_cma !== pe.comma) begin errors++; $display("FAIL w10.comma w=%0d got=%b exp=%b", j-1, s_cma, pe.comma); end
                checks++; if (s_data !== pe.data) begin errors++; $display("FAIL w10.data w=%0d got=%h exp=%h", j-1, s_data, pe.data); end
            end
            model(m, {6'h00, ws[j]}, {6'h00, K2}, 1, pe);
            have = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_broken_sync();
        test_loss();
        test_async_reset();
        test_param();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_sync.md
Name: serial_paralelo_sync

Overview:
Parametrised serial-to-parallel deserializer with comma-based word alignment and lock tracking. It runs on the serial bit clock only and derives word timing from an internal phase counter, so no word-rate clock is needed. It hunts for the COMMA pattern at any bit offset, declares lock after LOCK_COUNT aligned commas, delivers non-comma words, and drops lock after repeated off-phase commas. It sits at the receive end of the serial link, ahead of the word-level demux/FIFO logic.

Parameters:
WIDTH, 8, word width in bits (>=4)
COMMA, 8'hBC, alignment/idle symbol (WIDTH bits)
LOCK_COUNT, 4, aligned commas required for lock (>=1)
LOSS_COUNT, 3, consecutive off-phase commas that force loss of lock (>=1)

Ports:
clk_32f  in  1  serial bit clock; all logic on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
data_in  in  1  serial data, MSB first
active  out  1  high while LOCKED
valid_out  out  1  one-cycle strobe: data_out holds a new non-comma word
data_out  out  WIDTH  last delivered word
comma_out  out  1  one-cycle strobe: aligned comma received while LOCKED
align_err  out  1  one-cycle strobe: lock lost

Behaviour:
- Reset (reset=0, async): state=HUNT; sr, ph, comma_cnt, miss_cnt=0; active=0, valid_out=0, data_out=0, comma_out=0, align_err=0.
- Shift register: every cycle sr <= {sr[WIDTH-2:0], data_in}. All comparisons below use registered sr.
- Phase counter ph (0..WIDTH-1): increments and wraps every cycle. Boundary = (ph==WIDTH-1) in SYNC/LOCKED. In HUNT, ph is free-running and has no meaning.
- HUNT: any cycle with sr==COMMA sets ph<=0 and comma_cnt<=1. Next state is SYNC, or LOCKED directly if LOCK_COUNT==1. The next aligned word is therefore in sr exactly WIDTH cycles after detection.
- SYNC, at each boundary:
  - sr==COMMA: comma_cnt++. On reaching LOCK_COUNT, go to LOCKED and set active<=1.
  - sr!=COMMA: go to HUNT, clear comma_cnt.
  - Non-boundary cycles are ignored. valid_out stays 0.
- LOCKED, at each boundary:
  - sr!=COMMA: data_out<=sr, valid_out<=1 for one cycle.
  - sr==COMMA: comma_out<=1 for one cycle, data_out unchanged, miss_cnt<=0.
  - Output latency: 1 cycle after the boundary cycle.
- LOCKED, at a non-boundary cycle with sr==COMMA: miss_cnt++. When miss_cnt reaches LOSS_COUNT:
  - go to HUNT; active<=0, align_err<=1 for one cycle;
  - clear comma_cnt and miss_cnt; data_out holds its value.
  - An aligned and an off-phase comma cannot coincide: off-phase checks occur only on non-boundary cycles.
- Back-to-back commas in HUNT: the first detection wins. Further matches before the boundary are ignored once in SYNC.
- Strobes (valid_out, comma_out, align_err) are low on every cycle they are not explicitly set.
- Widths: comma_cnt is $clog2(LOCK_COUNT+1) bits and saturates. miss_cnt is $clog2(LOSS_COUNT+1) bits.
- Reset asserted mid-word or mid-lock: immediate return to reset values, no partial word output. After reset release, hunting starts from the next cycle.

Decomposition:
- Package serial_paralelo_pkg: state encoding localparams ST_HUNT=2'd0, ST_SYNC=2'd1, ST_LOCKED=2'd2; default COMMA constant K28_5=8'hBC.
- Sub-module sp_comma_detect(WIDTH, COMMA): shift register plus equality compare, outputs sr and is_comma. The top holds the FSM, ph, the counters and the output registers.

Test Plan:
- Reset then lock: 3 garbage bits, then 4×8'hBC, then 8'h55, 8'hA3 (defaults). Expect active=1 one cycle after the 4th comma boundary; valid_out pulses with data_out=8'h55, then 8'hA3, each WIDTH cycles apart.
- Aligned idle while locked: interleave 8'hBC between data words. Expect comma_out pulses, no valid_out, data_out holding the last data word.
- Broken sync: 2×8'hBC then 8'h00. Expect return to HUNT, active stays 0; 4 further aligned commas then lock.
- Loss of lock: while locked, inject 3 commas each shifted by 3 bits. Expect align_err one-cycle pulse and active=0 after the 3rd. A single shifted comma followed by an aligned comma must not drop lock.
- Async reset mid-word: pull reset low at ph=4 while locked. Expect all outputs 0 with no clock edge, then a relock sequence works.
- Parameter sweep: WIDTH=10, COMMA=10'h17C, LOCK_COUNT=1. Expect lock on the first comma; word 10'h2A5 delivered on the next boundary.
